bht_predictor: RTL
==================

BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 Parameter ADDR_W, default 32, width of PC and instruction buses.
REQ-002 Parameter IDX_W, default 8, table index width; table holds 2^IDX_W counters.
REQ-003 Parameter CNT_W, default 2, saturating counter width; legal range 2..4.
REQ-004 Parameter MODE, default 0, index mode: 0 = bimodal, 1 = gshare.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 rdy  input  1  global ready; low freezes all state.
REQ-008 pc_cur  input  ADDR_W  PC of instruction being fetched.
REQ-009 ins_cur  input  ADDR_W  instruction word at pc_cur.
REQ-010 pc_pred_enable  output  1  prediction valid.
REQ-011 pc_pred  output  ADDR_W  predicted next PC.
REQ-012 enable_from_rob  input  1  training strobe, one conditional branch per cycle.
REQ-013 if_jump  input  1  resolved direction of trained branch, 1 = taken.
REQ-014 pc_finish  input  ADDR_W  PC of trained branch.

Function
REQ-015 Prediction path SHALL be combinational from pc_cur, ins_cur and registered state; zero-cycle latency.
REQ-016 Predict index = pc_cur[IDX_W+1:2] when MODE=0; pc_cur[IDX_W+1:2] XOR ghr when MODE=1.
REQ-017 ghr: IDX_W-bit global history register; exists only when MODE=1.
REQ-018 Opcode 1101111 (JAL): pc_pred = pc_cur + sign-extended J-immediate, always taken.
REQ-019 Opcode 1100011 (B-type): pc_pred = pc_cur + sign-extended B-immediate if counter MSB = 1, else pc_cur + 4.
REQ-020 All other opcodes, including JALR: pc_pred = pc_cur + 4.
REQ-021 All PC arithmetic SHALL be modulo 2^ADDR_W; wrap-around is silent.
REQ-022 pc_pred_enable = NOT rst; during rst, pc_pred = pc_cur + 4.
REQ-023 Training SHALL occur on a rising edge with enable_from_rob=1, rdy=1 and rst=0.
REQ-024 Train index uses pc_finish and the ghr value before that edge's update, per REQ-016.
REQ-025 Counter update: if_jump=1 increments, saturating at 2^CNT_W-1; if_jump=0 decrements, saturating at 0.
REQ-026 MODE=1: on a training edge, ghr <= {ghr[IDX_W-2:0], if_jump}.
REQ-027 Same-cycle predict and train to the same index: prediction uses the pre-update counter; no bypass.
REQ-028 rdy=0: table and ghr hold; prediction outputs remain combinationally valid.
REQ-029 enable_from_rob=0: no state change.

Reset
REQ-030 Asynchronous rst=1 SHALL set every counter to weakly-not-taken, 2^(CNT_W-1)-1 (01 for CNT_W=2).
REQ-031 Asynchronous rst=1 SHALL clear ghr to 0.
REQ-032 rst asserted mid-training SHALL discard the pending update; the reset values win.
REQ-033 First training edge after rst deasserts SHALL behave normally.

Structure
REQ-034 Opcode constants, default parameter values and the weakly-not-taken constant SHALL live in a shared predictor package.
REQ-035 One sub-module, imm_decode, SHALL extract the sign-extended B and J immediates; counter table and ghr stay in the top module.
REQ-036 Counter table SHALL be a register array; no SRAM macro.

Verification
REQ-037 Reset, then pc_cur=0x1000, ins_cur=BEQ with imm=+16 -> pc_pred=0x1004, pc_pred_enable=1.
REQ-038 Two taken trainings at pc_finish=0x1000, then predict the same BEQ -> pc_pred=0x1010; a third taken training leaves the counter at 3.
REQ-039 pc_cur=0x2000, ins_cur=JAL with imm=-8 -> pc_pred=0x1FF8; pc_cur=0xFFFFFFFC with a non-branch -> pc_pred=0x0.
REQ-040 MODE=1: train taken, not-taken, taken at any PC -> ghr=0b101; the next predict at 0x0 reads index 5.
REQ-041 Train with rdy=0 -> no counter change; assert rst during a training cycle -> counter=1 and ghr=0 afterwards.
REQ-042 Same-cycle predict and train at index 0 with counter=1, if_jump=1 -> prediction not-taken this cycle, taken on the next cycle.

Source files
------------

// File: rtl/bht_predictor_pkg.sv
// Shared definitions for the branch history table predictor.
//
// Contents:
//   DEF_*            default parameter values used by the predictor modules
//   OPC_JAL          RV32 JAL opcode (unconditional, always predicted taken)
//   OPC_BRANCH       RV32 B-type opcode (conditional, predicted by counter MSB)
//   weak_not_taken() reset value of a CNT_W-bit saturating counter

package bht_predictor_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_IDX_W  = 8;
  localparam int DEF_CNT_W  = 2;
  localparam int DEF_MODE   = 0;   // 0 = bimodal, 1 = gshare

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Largest value whose MSB is still 0: the counter leans not-taken but a
  // single taken outcome flips the prediction.
  function automatic int weak_not_taken(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  // Reset value for the default counter width (01 for CNT_W = 2).
  localparam int DEF_WEAK_NOT_TAKEN = weak_not_taken(DEF_CNT_W);

endpackage

// File: rtl/bht_predictor_imm_decode.sv
// Instruction field extraction for the predictor.
//
// Ports:
//   ins     in   32      RV32 instruction word
//   opcode  out  7       ins[6:0]
//   b_imm   out  ADDR_W  sign-extended B-type branch offset
//   j_imm   out  ADDR_W  sign-extended J-type (JAL) offset

module imm_decode
  import bht_predictor_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [31:0]       ins,
  output logic [6:0]        opcode,
  output logic [ADDR_W-1:0] b_imm,
  output logic [ADDR_W-1:0] j_imm
);

  logic [12:0] b_raw;
  logic [20:0] j_raw;

  // RISC-V scrambles the offset bits; bit 0 is implicitly zero.
  assign b_raw  = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign j_raw  = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  assign opcode = ins[6:0];
  assign b_imm  = {{(ADDR_W-13){b_raw[12]}}, b_raw};
  assign j_imm  = {{(ADDR_W-21){j_raw[20]}}, j_raw};

endmodule

// File: rtl/bht_predictor.sv
// Branch history table next-PC predictor (bimodal or gshare indexing).
//
// Ports:
//   clk              in   1       clock, all state updates on rising edge
//   rst              in   1       asynchronous active-high reset
//   rdy              in   1       global ready; low freezes table and history
//   pc_cur           in   ADDR_W  PC being fetched
//   ins_cur          in   ADDR_W  instruction word at pc_cur
//   pc_pred_enable   out  1       prediction valid (low only during reset)
//   pc_pred          out  ADDR_W  predicted next PC (combinational)
//   enable_from_rob  in   1       train one resolved conditional branch
//   if_jump          in   1       resolved direction, 1 = taken
//   pc_finish        in   ADDR_W  PC of the branch being trained
//
// The prediction reads the registered counter, so a training update to the
// same entry in the same cycle is only visible from the next cycle on.

module bht_predictor
  import bht_predictor_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int CNT_W  = DEF_CNT_W,    // legal range 2..4
  parameter int MODE   = DEF_MODE      // 0 = bimodal, 1 = gshare
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic [ADDR_W-1:0] ins_cur,
  output logic              pc_pred_enable,
  output logic [ADDR_W-1:0] pc_pred,
  input  logic              enable_from_rob,
  input  logic              if_jump,
  input  logic [ADDR_W-1:0] pc_finish
);

  localparam int               ENTRIES  = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(weak_not_taken(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0]  cnt_q [ENTRIES];
  logic [IDX_W-1:0]  ghr;
  logic [IDX_W-1:0]  pred_idx;
  logic [IDX_W-1:0]  train_idx;
  logic              train_en;
  logic [CNT_W-1:0]  train_cnt;
  logic [6:0]        opcode;
  logic [ADDR_W-1:0] b_imm;
  logic [ADDR_W-1:0] j_imm;
  logic [ADDR_W-1:0] pc_seq;
  logic              unused_pc_finish;

  imm_decode #(
    .ADDR_W (ADDR_W)
  ) u_imm_decode (
    .ins    (ins_cur[31:0]),
    .opcode (opcode),
    .b_imm  (b_imm),
    .j_imm  (j_imm)
  );

  // Only the word-index bits of the trained PC select an entry.
  assign unused_pc_finish = ^pc_finish;

  // ghr is all-zero in bimodal mode, so both modes share one index formula.
  assign pred_idx  = pc_cur[IDX_W+1:2] ^ ghr;
  assign train_idx = pc_finish[IDX_W+1:2] ^ ghr;
  assign train_en  = rdy & enable_from_rob;
  assign train_cnt = cnt_q[train_idx];

  generate
    if (MODE == 1) begin : g_ghr
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ghr <= '0;
        end else if (train_en) begin
          ghr <= {ghr[IDX_W-2:0], if_jump};
        end
      end
    end else begin : g_no_ghr
      assign ghr = '0;
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values (train_idx uses the ghr before its shift).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the counter array is plain flops, so it is reset like any other
      // register; a defined weakly-not-taken start is part of the behaviour.
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= CNT_INIT;
      end
    end else if (train_en) begin
      if (if_jump) begin
        if (train_cnt != CNT_MAX) cnt_q[train_idx] <= train_cnt + CNT_W'(1);
      end else begin
        if (train_cnt != '0) cnt_q[train_idx] <= train_cnt - CNT_W'(1);
      end
    end
  end

  assign pc_seq         = pc_cur + ADDR_W'(4);
  assign pc_pred_enable = ~rst;

  // NOTE: pc_pred gets its fall-through value first so every path through
  // the block assigns it and no latch is inferred.
  always_comb begin
    pc_pred = pc_seq;
    if (!rst) begin
      if (opcode == OPC_JAL) begin
        pc_pred = pc_cur + j_imm;
      end else if (opcode == OPC_BRANCH && cnt_q[pred_idx][CNT_W-1]) begin
        pc_pred = pc_cur + b_imm;
      end
    end
  end

endmodule
